// File: rtl/rtb_pkg.sv
// rtl/rtb_pkg.sv - shared widths and types for the return-target-buffer controller
package rtb_pkg;

    localparam int RTB_DW    = 12;
    localparam int RTB_AW    = 5;
    localparam int RTB_DEPTH = 1 << RTB_AW;

    // Memory-port bundle field widths
    localparam int MEM_ADDR_W = RTB_AW;
    localparam int MEM_DATA_W = RTB_DW;
    localparam int CNT_W      = RTB_AW + 1;

    typedef logic [RTB_DW-1:0] rtb_addr_t;
    typedef logic [RTB_AW-1:0] rtb_ptr_t;
    typedef logic [CNT_W-1:0]  rtb_cnt_t;

endpackage

// File: rtl/rtb_if.sv
// rtl/rtb_if.sv - call/return/prediction and memory-port bundle of the RTB controller
interface rtb_if
    import rtb_pkg::*;
#(
    parameter int DW = RTB_DW,
    parameter int AW = RTB_AW
);

    logic          call_vld;
    logic [DW-1:0] call_addr;
    logic          ret_vld;
    logic          flush;
    logic          pred_vld;
    logic [DW-1:0] pred_addr;
    logic [AW:0]   depth;
    logic          ovf;
    logic          udf;
    logic          mem_cs;
    logic          mem_web;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [AW-1:0] mem_ra;
    logic [DW-1:0] mem_rd;

    modport master (
        output call_vld, call_addr, ret_vld, flush, mem_rd,
        input  pred_vld, pred_addr, depth, ovf, udf,
        input  mem_cs, mem_web, mem_wa, mem_wd, mem_ra
    );

    modport slave (
        input  call_vld, call_addr, ret_vld, flush, mem_rd,
        output pred_vld, pred_addr, depth, ovf, udf,
        output mem_cs, mem_web, mem_wa, mem_wd, mem_ra
    );

endinterface

// File: rtl/rtb_sram.sv
// rtl/rtb_sram.sv - 32x12 two-port RTB SRAM wrapper, registered read port
module rtb_sram
    import rtb_pkg::*;
#(
    parameter int DW = RTB_DW,
    parameter int AW = RTB_AW
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          web,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (cs) begin
            if (!web) begin
                mem[wa] <= wd;
            end
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/rtb_ctrl.sv
// rtl/rtb_ctrl.sv - 32-entry return-address stack controller over the RTB SRAM
module rtb_ctrl
    import rtb_pkg::*;
#(
    parameter int DW = RTB_DW,
    parameter int AW = RTB_AW
) (
    input  logic clk,
    input  logic rst,
    rtb_if.slave bus
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] FULL  = DEPTH[AW:0];

    logic [AW-1:0] sp, sp_n;
    logic [AW:0]   cnt, cnt_n;
    logic [DW-1:0] tos, tos_n;
    logic          ovf_q, ovf_n;
    logic          udf_q, udf_n;
    logic          wr;
    logic [AW-1:0] wa_q, wa_n;
    logic [DW-1:0] wd_q, wd_n;

    always_comb begin
        sp_n  = sp;
        cnt_n = cnt;
        tos_n = tos;
        ovf_n = ovf_q;
        udf_n = 1'b0;
        wr    = 1'b0;
        wa_n  = wa_q;
        wd_n  = wd_q;
        if (bus.flush) begin
            sp_n  = '0;
            cnt_n = '0;
            tos_n = '0;
        end else if (bus.call_vld && (!bus.ret_vld || cnt == '0)) begin
            wr    = 1'b1;
            wa_n  = sp;
            wd_n  = bus.call_addr;
            tos_n = bus.call_addr;
            sp_n  = sp + 1'b1;
            // A full stack overwrites its oldest slot, which is the one at sp
            if (cnt == FULL) begin
                ovf_n = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (bus.call_vld) begin
            wr    = 1'b1;
            wa_n  = sp - 1'b1;
            wd_n  = bus.call_addr;
            tos_n = bus.call_addr;
        end else if (bus.ret_vld) begin
            if (cnt == '0) begin
                udf_n = 1'b1;
            end else begin
                tos_n = bus.mem_rd;
                sp_n  = sp - 1'b1;
                cnt_n = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            cnt   <= '0;
            tos   <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
        end else begin
            sp    <= sp_n;
            cnt   <= cnt_n;
            tos   <= tos_n;
            ovf_q <= ovf_n;
            udf_q <= udf_n;
            wa_q  <= wa_n;
            wd_q  <= wd_n;
        end
    end

    // Read ahead two below the next write slot so mem_rd holds next-on-stack
    assign bus.mem_ra    = sp_n - 2'd2;
    assign bus.mem_cs    = !rst;
    assign bus.mem_web   = !(wr && !rst);
    assign bus.mem_wa    = wa_n;
    assign bus.mem_wd    = wd_n;
    assign bus.pred_vld  = (cnt != '0);
    assign bus.pred_addr = tos;
    assign bus.depth     = cnt;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;

endmodule
